button_ctrl: RTL and testbench

BUTTON_CTRL -- requirements
Module: button_ctrl

---
 rtl/button_ctrl.sv | 148 ++++++++++++++
 tb/tb_button_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// button_ctrl: multi-channel push-button front end.
//
// Each channel synchronises its raw button input, optionally debounces it, reports the
// debounced level, pulses on every accepted press and steps a small wrap-around state
// counter on each press (N_STATES = 2 gives a toggle).
//
// Build option:
//   BUTTON_CTRL_DEBOUNCE_EN defined   - per-channel debounce counters; a level change is
//                                       accepted after DEBOUNCE_CYCLES stable samples.
//   BUTTON_CTRL_DEBOUNCE_EN undefined - no counters; o_level is the synchroniser output.
//
// Ports:
//   i_clock  - system clock, rising edge
//   i_reset  - asynchronous active-low reset
//   i_signal - raw button inputs, bit i = channel i
//   i_clear  - synchronous per-channel state clear
//   o_level  - debounced button level
//   o_press  - one-cycle pulse per accepted rising edge
//   o_state  - channel i state in bits [i*STATE_W +: STATE_W]

module button_ctrl #(
  parameter int unsigned N_BUTTON        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned N_STATES        = 2,
  parameter int unsigned STATE_W         = 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [N_BUTTON-1:0]         i_signal,
  input  logic [N_BUTTON-1:0]         i_clear,
  output logic [N_BUTTON-1:0]         o_level,
  output logic [N_BUTTON-1:0]         o_press,
  output logic [N_BUTTON*STATE_W-1:0] o_state
);

  localparam logic [STATE_W-1:0] STATE_LAST = STATE_W'(N_STATES - 1);
  localparam logic [STATE_W-1:0] STATE_ONE  = STATE_W'(1);

  // Two-flop synchroniser
  logic [N_BUTTON-1:0] sync_meta_q;
  logic [N_BUTTON-1:0] sync_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= i_signal;
      sync_q      <= sync_meta_q;
    end
  end

  // level_cur is what o_level shows now; level_nxt is what it shows after the next edge.
  logic [N_BUTTON-1:0] level_cur;
  logic [N_BUTTON-1:0] level_nxt;

`ifdef BUTTON_CTRL_DEBOUNCE_EN
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_BUTTON-1:0] level_q;
  logic [CNT_W-1:0]    cnt_q [N_BUTTON];
  logic [CNT_W-1:0]    cnt_d [N_BUTTON];

  // The counter only ever reaches DEBOUNCE_CYCLES-1: the next differing sample is the
  // accepting one, which updates the level and clears the count, so it cannot wrap.
  always_comb begin
    level_nxt = level_q;
    for (int i = 0; i < N_BUTTON; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]     = '0;
        level_nxt[i] = sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      level_q <= '0;
      for (int i = 0; i < N_BUTTON; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_nxt;
      for (int i = 0; i < N_BUTTON; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level_cur = level_q;
`else
  assign level_cur = sync_q;
  assign level_nxt = sync_meta_q;
`endif

  assign o_level = level_cur;

  // Accepted rising edge: level is 0 now and becomes 1 on this edge
  logic [N_BUTTON-1:0] rise;
  assign rise = level_nxt & ~level_cur;

  logic [N_BUTTON-1:0] press_q;
  logic [STATE_W-1:0]  state_q [N_BUTTON];
  logic [STATE_W-1:0]  state_d [N_BUTTON];

  // Clear wins over a simultaneous advance; the press pulse is unaffected by clear.
  always_comb begin
    for (int i = 0; i < N_BUTTON; i++) begin
      state_d[i] = state_q[i];
      if (i_clear[i]) begin
        state_d[i] = '0;
      end else if (rise[i]) begin
        state_d[i] = (state_q[i] == STATE_LAST) ? '0 : state_q[i] + STATE_ONE;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      press_q <= '0;
      for (int i = 0; i < N_BUTTON; i++) begin
        state_q[i] <= '0;
      end
    end else begin
      press_q <= rise;
      for (int i = 0; i < N_BUTTON; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign o_press = press_q;

  always_comb begin
    o_state = '0;
    for (int i = 0; i < N_BUTTON; i++) begin
      o_state[i*STATE_W +: STATE_W] = state_q[i];
    end
  end

endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed scoreboard bench for button_ctrl (2 channels, 4-cycle debounce,
// 3-state cycle). The driver pushes every expected output change (cycle, level, press,
// state) into a queue; a monitor pops one entry per observed output change.

module tb_button_ctrl;

  localparam int NB   = 2;
  localparam int DC   = 4;
  localparam int NS   = 3;
  localparam int SW   = 2;
`ifdef BUTTON_CTRL_DEBOUNCE_EN
  localparam int LAT  = DC + 2;
  localparam int PRE  = 3;
`else
  localparam int LAT  = 2;
  localparam int PRE  = 1;
`endif
  localparam int HOLD = DC + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NB-1:0]    sig;
  logic [NB-1:0]    clr;
  logic [NB-1:0]    level;
  logic [NB-1:0]    press;
  logic [NB*SW-1:0] state;

  button_ctrl #(
    .N_BUTTON       (NB),
    .DEBOUNCE_CYCLES(DC),
    .N_STATES       (NS),
    .STATE_W        (SW)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_signal(sig),
    .i_clear (clr),
    .o_level (level),
    .o_press (press),
    .o_state (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [3:0] st;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] cur_level = '0;
  logic [3:0] cur_state = '0;
  logic       mon_en = 1'b0;
  logic [7:0] prev_o = '0;
  logic [7:0] now_o;
  ev_t        e;

  task automatic push(input int c, input logic [1:0] lvl, input logic [1:0] prs,
                      input logic [3:0] st);
    ev_t x;
    x.c = c; x.lvl = lvl; x.prs = prs; x.st = st;
    exp_q.push_back(x);
  endtask

  // Monitor: every change of the output bundle must match the next queued expectation
  always @(negedge clk) begin
    if (mon_en) begin
      now_o = {level, press, state};
      if (now_o !== prev_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event cyc=%0d got lvl=%b prs=%b st=%b, required no change",
                   cyc, level, press, state);
        end else begin
          e = exp_q.pop_front();
          if (e.c == cyc && e.lvl === level && e.prs === press && e.st === state) begin
            n_pass++;
          end else begin
            $display("FAIL event got cyc=%0d lvl=%b prs=%b st=%b, required cyc=%0d lvl=%b prs=%b st=%b",
                     cyc, level, press, state, e.c, e.lvl, e.prs, e.st);
          end
        end
      end
      prev_o = now_o;
    end
  end

  // Caller sits just after a rising edge. Press mask m for hold cycles; clear mask c is
  // asserted on the accepting edge. st_exp is the hand-computed state after the press.
  task automatic press_btn(input logic [1:0] m, input int hold, input logic [1:0] c,
                           input logic [3:0] st_exp);
    int k;
    k = cyc;
    push(k + LAT, cur_level | m, m, st_exp);
    if (hold == 1) begin
      push(k + LAT + 1, cur_level, 2'b00, st_exp);
    end else begin
      push(k + LAT + 1, cur_level | m, 2'b00, st_exp);
      push(k + hold + LAT, cur_level, 2'b00, st_exp);
    end
    cur_state = st_exp;
    sig = sig | m;
    for (int t = 1; t <= hold + LAT + 2; t++) begin
      @(posedge clk); #1;
      if (t == hold)    sig = sig & ~m;
      if (t == LAT - 1) clr = c;
      if (t == LAT)     clr = '0;
    end
  endtask

  task automatic clear_ch(input logic [1:0] m, input logic [3:0] st_exp);
    push(cyc + 1, cur_level, 2'b00, st_exp);
    clr = m;
    @(posedge clk); #1;
    clr = '0;
    cur_state = st_exp;
    @(posedge clk); #1;
  endtask

  task automatic drive0(input logic v, input int n);
    sig[0] = v;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    sig   = '0;
    clr   = '0;
    #2;
    n_checks++;
    if (level === '0 && press === '0 && state === '0) n_pass++;
    else $display("FAIL reset_state got lvl=%b prs=%b st=%b, required all zero",
                  level, press, state);
    prev_o = '0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end

`ifdef BUTTON_CTRL_DEBOUNCE_EN
    // Short streaks never reach the debounce threshold: no output change expected
    drive0(1'b1, 3);
    drive0(1'b0, 2);
    drive0(1'b1, 3);
    drive0(1'b0, 10);
`else
    // Single-cycle pulse passes straight through the synchroniser
    press_btn(2'b01, 1, 2'b00, 4'b0001);
    clear_ch(2'b01, 4'b0000);
`endif

    // Clean press on channel 0, channel 1 untouched
    press_btn(2'b01, HOLD, 2'b00, 4'b0001);
    clear_ch(2'b01, 4'b0000);
    press_btn(2'b01, HOLD, 2'b00, 4'b0001);
    press_btn(2'b01, HOLD, 2'b00, 4'b0010);
    // Accepted press from state 2 with a simultaneous clear: state 0, pulse still emitted
    press_btn(2'b01, HOLD, 2'b01, 4'b0000);

    // Channel 1 walks 1, 2, 0
    press_btn(2'b10, HOLD, 2'b00, 4'b0100);
    press_btn(2'b10, HOLD, 2'b00, 4'b1000);
    press_btn(2'b10, HOLD, 2'b00, 4'b0000);

    // Both channels at once
    press_btn(2'b11, HOLD, 2'b00, 4'b0101);

    // Reset mid-debounce with channel 0 held high
    sig[0] = 1'b1;
    repeat (PRE) begin
      @(posedge clk); #1;
    end
    push(cyc, 2'b00, 2'b00, 4'b0000);
    rst_n = 1'b0;
    cur_state = '0;
    @(negedge clk); #1;
    n_checks++;
    if (level === '0 && press === '0 && state === '0) n_pass++;
    else $display("FAIL in_reset got lvl=%b prs=%b st=%b, required all zero",
                  level, press, state);
    @(posedge clk); #1;
    rst_n = 1'b1;
    k = cyc;
    push(k + LAT, 2'b01, 2'b01, 4'b0001);
    push(k + LAT + 1, 2'b01, 2'b00, 4'b0001);
    push(k + HOLD + LAT, 2'b00, 2'b00, 4'b0001);
    cur_state = 4'b0001;
    for (int t = 1; t <= HOLD + LAT + 2; t++) begin
      @(posedge clk); #1;
      if (t == HOLD) sig[0] = 1'b0;
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL missing_events got %0d pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
